// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction-memory read port, pipeline control inputs and
// the fetched-instruction outputs towards decode and the register file.
interface instr_fetch_if;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA;
  logic        IMEM_ACK;
  logic        STALL;
  logic        BR_TAKEN;
  logic [31:0] BR_TARGET;
  logic [31:0] INSTR;
  logic        INSTR_VALID;
  logic [31:0] PC_OUT;
  logic [31:0] R15;

  modport master (
    output IMEM_REQ, IMEM_ADDR, INSTR, INSTR_VALID, PC_OUT, R15,
    input  IMEM_RDATA, IMEM_ACK, STALL, BR_TAKEN, BR_TARGET
  );

  modport slave (
    input  IMEM_REQ, IMEM_ADDR, INSTR, INSTR_VALID, PC_OUT, R15,
    output IMEM_RDATA, IMEM_ACK, STALL, BR_TAKEN, BR_TARGET
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding memory read, output register plus
// one-entry skid buffer, branch redirect with discard of an in-flight response.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          CLK,
  input  logic          nRESET,
  instr_fetch_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  logic [1:0]  state_r,      state_s;
  logic [31:0] fetch_pc_r,   fetch_pc_s;
  logic [31:0] imem_addr_r,  imem_addr_s;
  logic        imem_req_r,   imem_req_s;
  logic [31:0] out_instr_r,  out_instr_s;
  logic [31:0] out_pc_r,     out_pc_s;
  logic        out_valid_r,  out_valid_s;
  logic [31:0] skid_instr_r, skid_instr_s;
  logic [31:0] skid_pc_r,    skid_pc_s;
  logic        skid_valid_r, skid_valid_s;
  logic        discard_r,    discard_s;
  logic        consume_s, ack_s, deliver_s, hold_s;

  // Next-state decode for the fetch FSM, output register and skid buffer.
  always_comb begin
    consume_s    = out_valid_r & ~bus.STALL;
    ack_s        = (state_r == ST_REQ) & bus.IMEM_ACK;
    deliver_s    = ack_s & ~discard_r;
    // an unacknowledged request keeps its address even across a redirect
    hold_s       = (state_r == ST_REQ) & ~bus.IMEM_ACK;
    state_s      = state_r;
    fetch_pc_s   = fetch_pc_r;
    out_instr_s  = out_instr_r;
    out_pc_s     = out_pc_r;
    out_valid_s  = out_valid_r;
    skid_instr_s = skid_instr_r;
    skid_pc_s    = skid_pc_r;
    skid_valid_s = skid_valid_r;
    discard_s    = discard_r;

    if (bus.BR_TAKEN) begin
      fetch_pc_s   = word_align(bus.BR_TARGET);
      out_valid_s  = 1'b0;
      skid_valid_s = 1'b0;
      discard_s    = hold_s;
      state_s      = ST_REQ;
    end else begin
      if (ack_s) begin
        discard_s = 1'b0;
      end else begin
        discard_s = discard_r;
      end

      if (deliver_s) begin
        fetch_pc_s = fetch_pc_r + 32'd4;
      end else begin
        fetch_pc_s = fetch_pc_r;
      end

      if (consume_s || !out_valid_r) begin
        if (skid_valid_r) begin
          out_instr_s  = skid_instr_r;
          out_pc_s     = skid_pc_r;
          out_valid_s  = 1'b1;
          skid_valid_s = deliver_s;
          if (deliver_s) begin
            skid_instr_s = bus.IMEM_RDATA;
            skid_pc_s    = imem_addr_r;
          end else begin
            skid_instr_s = skid_instr_r;
            skid_pc_s    = skid_pc_r;
          end
        end else if (deliver_s) begin
          out_instr_s = bus.IMEM_RDATA;
          out_pc_s    = imem_addr_r;
          out_valid_s = 1'b1;
        end else begin
          out_valid_s = 1'b0;
        end
      end else if (deliver_s) begin
        skid_instr_s = bus.IMEM_RDATA;
        skid_pc_s    = imem_addr_r;
        skid_valid_s = 1'b1;
      end else begin
        skid_valid_s = skid_valid_r;
      end

      case (state_r)
        ST_IDLE: state_s = ST_REQ;
        ST_REQ: begin
          if (ack_s) begin
            state_s = skid_valid_s ? ST_WAIT : ST_REQ;
          end else begin
            state_s = ST_REQ;
          end
        end
        ST_WAIT: state_s = skid_valid_s ? ST_WAIT : ST_REQ;
        default: state_s = ST_IDLE;
      endcase
    end

    if (hold_s) begin
      imem_addr_s = imem_addr_r;
    end else begin
      imem_addr_s = fetch_pc_s;
    end
    imem_req_s = (state_s == ST_REQ);
  end

  // State and output registers; reset drives every output to its idle value at once.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_r      <= ST_IDLE;
      fetch_pc_r   <= RESET_PC;
      imem_addr_r  <= RESET_PC;
      imem_req_r   <= 1'b0;
      out_instr_r  <= 32'd0;
      out_pc_r     <= RESET_PC;
      out_valid_r  <= 1'b0;
      skid_instr_r <= 32'd0;
      skid_pc_r    <= 32'd0;
      skid_valid_r <= 1'b0;
      discard_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      fetch_pc_r   <= fetch_pc_s;
      imem_addr_r  <= imem_addr_s;
      imem_req_r   <= imem_req_s;
      out_instr_r  <= out_instr_s;
      out_pc_r     <= out_pc_s;
      out_valid_r  <= out_valid_s;
      skid_instr_r <= skid_instr_s;
      skid_pc_r    <= skid_pc_s;
      skid_valid_r <= skid_valid_s;
      discard_r    <= discard_s;
    end
  end

  assign bus.IMEM_REQ    = imem_req_r;
  assign bus.IMEM_ADDR   = imem_addr_r;
  assign bus.INSTR       = out_instr_r;
  assign bus.INSTR_VALID = out_valid_r;
  assign bus.PC_OUT      = out_pc_r;
  assign bus.R15         = out_pc_r + 32'd8;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic; a monitor
// checks every consumed instruction against a program-order stream model.
module tb_instr_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic CLK;
  logic nRESET;
  instr_fetch_if bus_if();

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .CLK    (CLK),
    .nRESET (nRESET),
    .bus    (bus_if)
  );

  int vectors     = 0;
  int miscompares = 0;
  int consumed    = 0;
  logic [31:0] redirect_q [$];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // one cycle of stimulus; memory answers with the word for the requested address
  task automatic drive(input logic ack, input logic stall, input logic br, input logic [31:0] tgt);
    @(negedge CLK);
    bus_if.IMEM_ACK   = ack;
    bus_if.IMEM_RDATA = (ack && bus_if.IMEM_REQ) ? mem_word(bus_if.IMEM_ADDR) : $urandom;
    bus_if.STALL      = stall;
    bus_if.BR_TAKEN   = br;
    bus_if.BR_TARGET  = tgt;
    if (br) redirect_q.push_back({tgt[31:2], 2'b00});
    #1;
  endtask

  // Monitor: consumed instructions must follow program order from the last redirect.
  initial begin : monitor
    logic [31:0] exp_pc;
    logic        pend;
    logic [31:0] pend_addr;
    exp_pc    = RESET_PC;
    pend      = 1'b0;
    pend_addr = 32'd0;
    forever begin
      @(negedge CLK);
      #2;
      if (nRESET !== 1'b1) begin
        exp_pc = RESET_PC;
        pend   = 1'b0;
        redirect_q.delete();
      end else begin
        if (pend) begin
          check("req_held", {31'd0, bus_if.IMEM_REQ}, 32'd1);
          check("addr_held", bus_if.IMEM_ADDR, pend_addr);
        end
        if (bus_if.IMEM_REQ === 1'b1)
          check("addr_align", {30'd0, bus_if.IMEM_ADDR[1:0]}, 32'd0);
        if (bus_if.INSTR_VALID === 1'b1 && bus_if.STALL === 1'b0) begin
          check("pc_out", bus_if.PC_OUT, exp_pc);
          check("instr", bus_if.INSTR, mem_word(exp_pc));
          check("r15", bus_if.R15, exp_pc + 32'd8);
          exp_pc = exp_pc + 32'd4;
          consumed++;
        end
        if (bus_if.BR_TAKEN === 1'b1) begin
          if (redirect_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL redirect_q: got empty queue expected a pending target");
          end else begin
            exp_pc = redirect_q.pop_front();
          end
        end
        pend      = (bus_if.IMEM_REQ === 1'b1) && (bus_if.IMEM_ACK !== 1'b1);
        pend_addr = bus_if.IMEM_ADDR;
      end
    end
  end

  initial begin : stim
    int          base;
    logic        r_ack, r_stall, r_br;
    logic [31:0] r_tgt;
    nRESET            = 1'b1;
    bus_if.IMEM_ACK   = 1'b0;
    bus_if.IMEM_RDATA = 32'd0;
    bus_if.STALL      = 1'b0;
    bus_if.BR_TAKEN   = 1'b0;
    bus_if.BR_TARGET  = 32'd0;
    #2 nRESET = 1'b0;
    #21;
    check("rst_req", {31'd0, bus_if.IMEM_REQ}, 32'd0);
    check("rst_addr", bus_if.IMEM_ADDR, RESET_PC);
    check("rst_instr", bus_if.INSTR, 32'd0);
    check("rst_valid", {31'd0, bus_if.INSTR_VALID}, 32'd0);
    check("rst_pc", bus_if.PC_OUT, RESET_PC);
    check("rst_r15", bus_if.R15, RESET_PC + 32'd8);

    // streaming with ACK tied high
    @(negedge CLK);
    nRESET          = 1'b1;
    bus_if.IMEM_ACK = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      check("stream_req", {31'd0, bus_if.IMEM_REQ}, 32'd1);
      check("stream_addr", bus_if.IMEM_ADDR, RESET_PC + 32'(4 * i));
      check("stream_valid", {31'd0, bus_if.INSTR_VALID}, (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) begin
        check("stream_pc", bus_if.PC_OUT, RESET_PC + 32'(4 * (i - 1)));
        check("stream_r15", bus_if.R15, RESET_PC + 32'(4 * (i - 1) + 8));
      end
    end

    // three stall cycles: one word lands in the skid buffer and requests stop
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'd0);
      check("stall_req", {31'd0, bus_if.IMEM_REQ}, 32'd0);
    end
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    check("drain_req", {31'd0, bus_if.IMEM_REQ}, 32'd0);
    check("drain_valid", {31'd0, bus_if.INSTR_VALID}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    check("resume_req", {31'd0, bus_if.IMEM_REQ}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 32'd0);

    // branch in the same cycle as ACK
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    check("br_valid", {31'd0, bus_if.INSTR_VALID}, 32'd0);
    check("br_addr", bus_if.IMEM_ADDR, 32'h0000_0100);
    check("br_req", {31'd0, bus_if.IMEM_REQ}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0);

    // branch while memory is slow: old address held, its data discarded
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    check("slow_addr", bus_if.IMEM_ADDR, 32'h0000_010C);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0200);
    check("slow_br_addr", bus_if.IMEM_ADDR, 32'h0000_010C);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      check("slow_hold", bus_if.IMEM_ADDR, 32'h0000_010C);
    end
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    check("slow_ack_addr", bus_if.IMEM_ADDR, 32'h0000_010C);
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    check("slow_new_addr", bus_if.IMEM_ADDR, 32'h0000_0200);
    check("slow_new_valid", {31'd0, bus_if.INSTR_VALID}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0);

    // wrap at the top of the address space; low target bits ignored
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    check("wrap_addr0", bus_if.IMEM_ADDR, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    check("wrap_addr1", bus_if.IMEM_ADDR, 32'h0000_0000);
    check("wrap_pc", bus_if.PC_OUT, 32'hFFFF_FFFC);
    check("wrap_r15", bus_if.R15, 32'h0000_0004);
    drive(1'b1, 1'b0, 1'b0, 32'd0);

    // asynchronous reset between edges with a request outstanding
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    #2 nRESET = 1'b0;
    #1;
    check("areset_req", {31'd0, bus_if.IMEM_REQ}, 32'd0);
    check("areset_valid", {31'd0, bus_if.INSTR_VALID}, 32'd0);
    check("areset_instr", bus_if.INSTR, 32'd0);
    check("areset_addr", bus_if.IMEM_ADDR, RESET_PC);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      check("inreset_req", {31'd0, bus_if.IMEM_REQ}, 32'd0);
    end
    @(negedge CLK);
    nRESET = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    check("rel_req", {31'd0, bus_if.IMEM_REQ}, 32'd1);
    check("rel_addr", bus_if.IMEM_ADDR, RESET_PC);
    check("rel_valid", {31'd0, bus_if.INSTR_VALID}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    check("rel_pc", bus_if.PC_OUT, RESET_PC);
    check("rel_instr", bus_if.INSTR, mem_word(RESET_PC));

    // random traffic
    base = consumed;
    for (int i = 0; i < 3000; i++) begin
      r_ack   = ($urandom_range(0, 9) < 7);
      r_stall = ($urandom_range(0, 9) < 3);
      r_br    = ($urandom_range(0, 39) == 0);
      r_tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom;
      drive(r_ack, r_stall, r_br, r_tgt);
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 32'd0);
    check("throughput", {31'd0, (consumed - base) >= 300}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
